// File: rtl/julia_pkg.sv
// Shared types and default sizing for the Julia compute array dispatch path.
package julia_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } dispatch_state_t;

  localparam int unsigned NUM_JULIA_DEF = 8;
  localparam int unsigned WIDTH_DEF     = 640;
  localparam int unsigned HEIGHT_DEF    = 480;

endpackage

// File: rtl/julia_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module julia_rr_pick #(
  parameter int unsigned NUM_JULIA = 8,
  localparam int unsigned PTR_W = $clog2(NUM_JULIA)
) (
  input  logic [NUM_JULIA-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic                 any,
  output logic [NUM_JULIA-1:0] grant,
  output logic [PTR_W-1:0]     grant_idx
);

  always_comb begin
    logic [PTR_W-1:0] k;
    k         = '0;
    any       = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_JULIA; i++) begin
      k = PTR_W'((32'(ptr) + i) % NUM_JULIA);
      if (!any && req[k]) begin
        any       = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = k;
      end
    end
  end

endmodule

// File: rtl/julia_dispatch.sv
// Raster-order pixel dispatcher: hands one pixel per cycle to the next idle Julia core
// (round-robin) and pulses frame_done once every issued pixel has been written back.
module julia_dispatch
  import julia_pkg::*;
#(
  parameter int unsigned NUM_JULIA = NUM_JULIA_DEF,
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned HEIGHT    = HEIGHT_DEF,
  parameter int unsigned X_W       = 10,
  parameter int unsigned Y_W       = 9
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [31:0]          frame_base,
  input  logic [NUM_JULIA-1:0] free,
  output logic [NUM_JULIA-1:0] load,
  output logic [X_W-1:0]       load_x,
  output logic [Y_W-1:0]       load_y,
  output logic [31:0]          load_address,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned PTR_W = $clog2(NUM_JULIA);
  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_JULIA - 1);

  dispatch_state_t state_q, state_d;
  logic [NUM_JULIA-1:0] idle_q, idle_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  // Address of pixel (0, y): frame_base plus y*WIDTH, kept as a running sum.
  logic [31:0]          line_base_q, line_base_d;

  logic [NUM_JULIA-1:0] load_q, load_d;
  logic [X_W-1:0]       load_x_q, load_x_d;
  logic [Y_W-1:0]       load_y_q, load_y_d;
  logic [31:0]          load_address_q, load_address_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  logic                 pick_any;
  logic [NUM_JULIA-1:0] pick_grant;
  logic [PTR_W-1:0]     pick_idx;

  julia_rr_pick #(
    .NUM_JULIA(NUM_JULIA)
  ) u_rr_pick (
    .req      (idle_q),
    .ptr      (rr_ptr_q),
    .any      (pick_any),
    .grant    (pick_grant),
    .grant_idx(pick_idx)
  );

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    x_d            = x_q;
    y_d            = y_q;
    line_base_d    = line_base_q;
    load_d         = '0;
    load_x_d       = load_x_q;
    load_y_d       = load_y_q;
    load_address_d = load_address_q;
    frame_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          line_base_d = frame_base;
          x_d         = '0;
          y_d         = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (pick_any) begin
          load_d         = pick_grant;
          load_x_d       = x_q;
          load_y_d       = y_q;
          load_address_d = line_base_q + 32'(x_q);
          rr_ptr_d       = (pick_idx == PTR_LAST) ? '0 : pick_idx + PTR_W'(1);
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              state_d = DRAIN;
            end else begin
              y_d         = y_q + Y_W'(1);
              line_base_d = line_base_q + WIDTH;
            end
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
      end
      DRAIN: begin
        if (&idle_q) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // free only revives busy cores; a grant and a free can land in the same cycle.
    idle_d = (idle_q & ~load_d) | (free & ~idle_q);
    busy_d = (state_d != IDLE) || frame_done_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      idle_q         <= '1;
      rr_ptr_q       <= '0;
      x_q            <= '0;
      y_q            <= '0;
      line_base_q    <= '0;
      load_q         <= '0;
      load_x_q       <= '0;
      load_y_q       <= '0;
      load_address_q <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idle_q         <= idle_d;
      rr_ptr_q       <= rr_ptr_d;
      x_q            <= x_d;
      y_q            <= y_d;
      line_base_q    <= line_base_d;
      load_q         <= load_d;
      load_x_q       <= load_x_d;
      load_y_q       <= load_y_d;
      load_address_q <= load_address_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign load         = load_q;
  assign load_x       = load_x_q;
  assign load_y       = load_y_q;
  assign load_address = load_address_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule
